// File: rtl/candidate_collector.sv
// Collects accepted classifier candidates, rescales them to camera coordinates and queues them for the host.
// Optional merge of near-duplicate detections is compiled in with `CANDIDATE_MERGE_EN.
module candidate_collector #(
  parameter int DATA_WIDTH_12                = 12,
  parameter int FIFO_DEPTH                   = 16,
  parameter int SCALE_X_Q8                   = 256,
  parameter int SCALE_Y_Q8                   = 256,
  parameter int FRAME_ORIGINAL_CAMERA_WIDTH  = 10,
  parameter int FRAME_ORIGINAL_CAMERA_HEIGHT = 10,
  parameter int MERGE_DIST                   = 2
) (
  input  logic                     clk_fpga,
  input  logic                     reset_fpga,
  input  logic                     frame_start,
  input  logic                     inspect_done,
  input  logic                     candidate,
  input  logic [DATA_WIDTH_12-1:0] resize_x,
  input  logic [DATA_WIDTH_12-1:0] resize_y,
  input  logic                     rd_req,
  output logic                     o_valid,
  output logic [DATA_WIDTH_12-1:0] o_x,
  output logic [DATA_WIDTH_12-1:0] o_y,
  output logic                     o_full,
  output logic [DATA_WIDTH_12-1:0] o_count,
  output logic                     o_overflow
);

  localparam int DW = DATA_WIDTH_12;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = DW + 16;
  localparam logic [PW-1:0] SCALE_X = PW'(SCALE_X_Q8);
  localparam logic [PW-1:0] SCALE_Y = PW'(SCALE_Y_Q8);
  localparam logic [PW-1:0] MAX_X   = PW'(FRAME_ORIGINAL_CAMERA_WIDTH - 1);
  localparam logic [PW-1:0] MAX_Y   = PW'(FRAME_ORIGINAL_CAMERA_HEIGHT - 1);
  localparam logic [AW:0]   DEPTH   = (AW+1)'(FIFO_DEPTH);

  logic          s1_valid_q;
  logic [DW-1:0] s1_x_q, s1_y_q;
  logic [PW-1:0] px, py, ox_wide, oy_wide;
  logic [DW-1:0] ox, oy;
  logic          accept;

  logic [DW-1:0] mem_x [FIFO_DEPTH];
  logic [DW-1:0] mem_y [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   occ_q, occ_d;
  logic [DW-1:0] count_q, count_d;
  logic          overflow_q;
  logic          push, pop, full;

  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
    end else begin
      s1_valid_q <= inspect_done && candidate;
      if (inspect_done && candidate) begin
        s1_x_q <= resize_x;
        s1_y_q <= resize_y;
      end
    end
  end

  // Products are kept wide enough for any 16-bit scale so the clamp sees the true value.
  always_comb begin
    px      = PW'(s1_x_q) * SCALE_X;
    py      = PW'(s1_y_q) * SCALE_Y;
    ox_wide = px >> 8;
    oy_wide = py >> 8;
    ox      = (ox_wide > MAX_X) ? MAX_X[DW-1:0] : ox_wide[DW-1:0];
    oy      = (oy_wide > MAX_Y) ? MAX_Y[DW-1:0] : oy_wide[DW-1:0];
  end

`ifdef CANDIDATE_MERGE_EN
  logic          hist_valid_q;
  logic [DW-1:0] last_x_q, last_y_q;
  logic [DW-1:0] dx, dy;
  logic          near;

  always_comb begin
    dx     = (s1_x_q >= last_x_q) ? (s1_x_q - last_x_q) : (last_x_q - s1_x_q);
    dy     = (s1_y_q >= last_y_q) ? (s1_y_q - last_y_q) : (last_y_q - s1_y_q);
    near   = hist_valid_q && (dx <= DW'(MERGE_DIST)) && (dy <= DW'(MERGE_DIST));
    accept = s1_valid_q && !near && !frame_start;
  end

  always_ff @(posedge clk_fpga) begin
    if (reset_fpga || frame_start) begin
      hist_valid_q <= 1'b0;
      last_x_q     <= '0;
      last_y_q     <= '0;
    end else if (accept) begin
      hist_valid_q <= 1'b1;
      last_x_q     <= s1_x_q;
      last_y_q     <= s1_y_q;
    end
  end
`else
  assign accept = s1_valid_q && !frame_start;
`endif

  // A pop is only honoured against the registered non-empty flag, so push+pop on empty just pushes.
  always_comb begin
    full  = (occ_q == DEPTH);
    pop   = rd_req && (occ_q != '0) && !frame_start;
    push  = accept && (!full || pop);
    occ_d = occ_q;
    if (push && !pop) occ_d = occ_q + 1'b1;
    else if (pop && !push) occ_d = occ_q - 1'b1;
    count_d = count_q;
    if (accept && (count_q != {DW{1'b1}})) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk_fpga) begin
    if (push) begin
      mem_x[wr_ptr_q] <= ox;
      mem_y[wr_ptr_q] <= oy;
    end
  end

  always_ff @(posedge clk_fpga) begin
    if (reset_fpga || frame_start) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      occ_q   <= occ_d;
      count_q <= count_d;
      if (accept && full && !pop) overflow_q <= 1'b1;
    end
  end

  assign o_valid    = (occ_q != '0);
  assign o_full     = full;
  assign o_x        = o_valid ? mem_x[rd_ptr_q] : '0;
  assign o_y        = o_valid ? mem_y[rd_ptr_q] : '0;
  assign o_count    = count_q;
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_candidate_collector.sv
// Directed bench for candidate_collector with x scale 1.5, y scale 2.0 and 10x10 clamp limits.
// Merge expectations follow `CANDIDATE_MERGE_EN.
module tb_candidate_collector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        inspect_done = 1'b0;
  logic        candidate = 1'b0;
  logic [11:0] resize_x = '0;
  logic [11:0] resize_y = '0;
  logic        rd_req = 1'b0;
  logic        o_valid, o_full, o_overflow;
  logic [11:0] o_x, o_y, o_count;

  int tests = 0;
  int fails = 0;

  candidate_collector #(
    .DATA_WIDTH_12(12), .FIFO_DEPTH(16), .SCALE_X_Q8(384), .SCALE_Y_Q8(512),
    .FRAME_ORIGINAL_CAMERA_WIDTH(10), .FRAME_ORIGINAL_CAMERA_HEIGHT(10), .MERGE_DIST(2)
  ) dut (
    .clk_fpga(clk), .reset_fpga(reset), .frame_start(frame_start),
    .inspect_done(inspect_done), .candidate(candidate),
    .resize_x(resize_x), .resize_y(resize_y), .rd_req(rd_req),
    .o_valid(o_valid), .o_x(o_x), .o_y(o_y), .o_full(o_full),
    .o_count(o_count), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  // Expected camera coordinates: x = floor(1.5*rx), y = 2*ry, both clamped to 9.
  function automatic logic [11:0] ex(input int rx);
    int v;
    v = (rx * 384) >> 8;
    return (v > 9) ? 12'd9 : 12'(v);
  endfunction

  function automatic logic [11:0] ey(input int ry);
    int v;
    v = (ry * 512) >> 8;
    return (v > 9) ? 12'd9 : 12'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int rx, input int ry);
    resize_x = 12'(rx);
    resize_y = 12'(ry);
    inspect_done = 1'b1;
    candidate = 1'b1;
    tick();
    inspect_done = 1'b0;
    candidate = 1'b0;
  endtask

  task automatic pop();
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic new_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tests++; if (o_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %0b expected 0", o_valid); end
    tests++; if (o_x !== 12'd0) begin fails++; $display("[TB] FAIL reset_x: got %0d expected 0", o_x); end
    tests++; if (o_y !== 12'd0) begin fails++; $display("[TB] FAIL reset_y: got %0d expected 0", o_y); end
    tests++; if (o_full !== 1'b0) begin fails++; $display("[TB] FAIL reset_full: got %0b expected 0", o_full); end
    tests++; if (o_count !== 12'd0) begin fails++; $display("[TB] FAIL reset_count: got %0d expected 0", o_count); end
    tests++; if (o_overflow !== 1'b0) begin fails++; $display("[TB] FAIL reset_overflow: got %0b expected 0", o_overflow); end
  endtask

  task automatic test_basic();
    send(3, 4);
    tests++; if (o_valid !== 1'b0) begin fails++; $display("[TB] FAIL basic_latency: got %0b expected 0", o_valid); end
    tick();
    tests++; if (o_valid !== 1'b1) begin fails++; $display("[TB] FAIL basic_valid: got %0b expected 1", o_valid); end
    tests++; if (o_x !== 12'd4) begin fails++; $display("[TB] FAIL basic_x: got %0d expected 4", o_x); end
    tests++; if (o_y !== 12'd8) begin fails++; $display("[TB] FAIL basic_y: got %0d expected 8", o_y); end
    tests++; if (o_count !== 12'd1) begin fails++; $display("[TB] FAIL basic_count: got %0d expected 1", o_count); end
    pop();
    tests++; if (o_valid !== 1'b0) begin fails++; $display("[TB] FAIL basic_pop: got %0b expected 0", o_valid); end
    // Rejected verdicts and reads on empty must both be no-ops.
    resize_x = 12'd7;
    resize_y = 12'd7;
    inspect_done = 1'b1;
    rd_req = 1'b1;
    tick();
    inspect_done = 1'b0;
    rd_req = 1'b0;
    tick();
    tick();
    tests++; if (o_valid !== 1'b0) begin fails++; $display("[TB] FAIL reject_valid: got %0b expected 0", o_valid); end
    tests++; if (o_count !== 12'd1) begin fails++; $display("[TB] FAIL reject_count: got %0d expected 1", o_count); end
  endtask

  task automatic test_truncate_clamp();
    new_frame();
    send(5, 5);
    send(9, 9);
    tick();
    tests++; if (o_count !== 12'd2) begin fails++; $display("[TB] FAIL trunc_count: got %0d expected 2", o_count); end
    tests++; if (o_x !== 12'd7) begin fails++; $display("[TB] FAIL trunc_x: got %0d expected 7", o_x); end
    tests++; if (o_y !== 12'd9) begin fails++; $display("[TB] FAIL trunc_y_clamp: got %0d expected 9", o_y); end
    pop();
    tests++; if (o_x !== 12'd9) begin fails++; $display("[TB] FAIL clamp_x: got %0d expected 9", o_x); end
    tests++; if (o_y !== 12'd9) begin fails++; $display("[TB] FAIL clamp_y: got %0d expected 9", o_y); end
    pop();
    tests++; if (o_valid !== 1'b0) begin fails++; $display("[TB] FAIL trunc_drain: got %0b expected 0", o_valid); end
  endtask

  task automatic test_overflow();
    new_frame();
    for (int i = 0; i < 17; i++) send((i * 3) % 11, i % 5);
    tick();
    tick();
    tests++; if (o_full !== 1'b1) begin fails++; $display("[TB] FAIL ovf_full: got %0b expected 1", o_full); end
    tests++; if (o_overflow !== 1'b1) begin fails++; $display("[TB] FAIL ovf_flag: got %0b expected 1", o_overflow); end
    tests++; if (o_count !== 12'd17) begin fails++; $display("[TB] FAIL ovf_count: got %0d expected 17", o_count); end
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (o_valid !== 1'b1 || o_x !== ex((i * 3) % 11) || o_y !== ey(i % 5)) begin
        fails++;
        $display("[TB] FAIL ovf_entry%0d: got v=%0b (%0d,%0d) expected v=1 (%0d,%0d)",
                 i, o_valid, o_x, o_y, ex((i * 3) % 11), ey(i % 5));
      end
      pop();
    end
    tests++; if (o_valid !== 1'b0) begin fails++; $display("[TB] FAIL ovf_drained: got %0b expected 0", o_valid); end
    tests++; if (o_overflow !== 1'b1) begin fails++; $display("[TB] FAIL ovf_sticky: got %0b expected 1", o_overflow); end
  endtask

  task automatic test_frame_flush();
    for (int i = 0; i < 5; i++) send((i * 3) % 11, 1);
    tick();
    tick();
    tests++; if (o_valid !== 1'b1) begin fails++; $display("[TB] FAIL flush_pre_valid: got %0b expected 1", o_valid); end
    send(8, 2);
    new_frame();
    tests++; if (o_valid !== 1'b0) begin fails++; $display("[TB] FAIL flush_valid: got %0b expected 0", o_valid); end
    tests++; if (o_count !== 12'd0) begin fails++; $display("[TB] FAIL flush_count: got %0d expected 0", o_count); end
    tests++; if (o_overflow !== 1'b0) begin fails++; $display("[TB] FAIL flush_overflow: got %0b expected 0", o_overflow); end
    tick();
    tick();
    tick();
    tests++; if (o_valid !== 1'b0) begin fails++; $display("[TB] FAIL flush_inflight_valid: got %0b expected 0", o_valid); end
    tests++; if (o_count !== 12'd0) begin fails++; $display("[TB] FAIL flush_inflight_count: got %0d expected 0", o_count); end
  endtask

  task automatic test_full_simul();
    new_frame();
    for (int i = 0; i < 16; i++) send((i * 3) % 11, 0);
    tick();
    tick();
    tests++; if (o_full !== 1'b1) begin fails++; $display("[TB] FAIL simul_pre_full: got %0b expected 1", o_full); end
    send(10, 0);
    pop();
    tests++; if (o_full !== 1'b1) begin fails++; $display("[TB] FAIL simul_full: got %0b expected 1", o_full); end
    tests++; if (o_overflow !== 1'b0) begin fails++; $display("[TB] FAIL simul_overflow: got %0b expected 0", o_overflow); end
    tests++; if (o_count !== 12'd17) begin fails++; $display("[TB] FAIL simul_count: got %0d expected 17", o_count); end
    for (int i = 1; i < 17; i++) begin
      logic [11:0] wx;
      wx = (i == 16) ? 12'd9 : ex((i * 3) % 11);
      tests++;
      if (o_valid !== 1'b1 || o_x !== wx || o_y !== 12'd0) begin
        fails++;
        $display("[TB] FAIL simul_entry%0d: got v=%0b (%0d,%0d) expected v=1 (%0d,0)", i, o_valid, o_x, o_y, wx);
      end
      pop();
    end
    tests++; if (o_valid !== 1'b0) begin fails++; $display("[TB] FAIL simul_drained: got %0b expected 0", o_valid); end
  endtask

  task automatic test_same_cycle();
    send(2, 2);
    tick();
    resize_x = 12'd6;
    resize_y = 12'd3;
    inspect_done = 1'b1;
    candidate = 1'b1;
    frame_start = 1'b1;
    tick();
    inspect_done = 1'b0;
    candidate = 1'b0;
    frame_start = 1'b0;
    tests++; if (o_valid !== 1'b0) begin fails++; $display("[TB] FAIL same_cleared: got %0b expected 0", o_valid); end
    tests++; if (o_count !== 12'd0) begin fails++; $display("[TB] FAIL same_count0: got %0d expected 0", o_count); end
    tick();
    tests++; if (o_valid !== 1'b1) begin fails++; $display("[TB] FAIL same_valid: got %0b expected 1", o_valid); end
    tests++; if (o_x !== 12'd9 || o_y !== 12'd6) begin fails++; $display("[TB] FAIL same_xy: got (%0d,%0d) expected (9,6)", o_x, o_y); end
    tests++; if (o_count !== 12'd1) begin fails++; $display("[TB] FAIL same_count1: got %0d expected 1", o_count); end
    pop();
  endtask

  task automatic test_merge();
    new_frame();
    send(4, 4);
    send(5, 6);
    send(7, 4);
    tick();
    tick();
`ifdef CANDIDATE_MERGE_EN
    tests++; if (o_count !== 12'd2) begin fails++; $display("[TB] FAIL merge_count: got %0d expected 2", o_count); end
    tests++; if (o_x !== 12'd6 || o_y !== 12'd8) begin fails++; $display("[TB] FAIL merge_e0: got (%0d,%0d) expected (6,8)", o_x, o_y); end
    pop();
    tests++; if (o_x !== 12'd9 || o_y !== 12'd8) begin fails++; $display("[TB] FAIL merge_e1: got (%0d,%0d) expected (9,8)", o_x, o_y); end
    pop();
`else
    tests++; if (o_count !== 12'd3) begin fails++; $display("[TB] FAIL merge_count: got %0d expected 3", o_count); end
    tests++; if (o_x !== 12'd6 || o_y !== 12'd8) begin fails++; $display("[TB] FAIL merge_e0: got (%0d,%0d) expected (6,8)", o_x, o_y); end
    pop();
    tests++; if (o_x !== 12'd7 || o_y !== 12'd9) begin fails++; $display("[TB] FAIL merge_e1: got (%0d,%0d) expected (7,9)", o_x, o_y); end
    pop();
    tests++; if (o_x !== 12'd9 || o_y !== 12'd8) begin fails++; $display("[TB] FAIL merge_e2: got (%0d,%0d) expected (9,8)", o_x, o_y); end
    pop();
`endif
    tests++; if (o_valid !== 1'b0) begin fails++; $display("[TB] FAIL merge_drained: got %0b expected 0", o_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_truncate_clamp();
    test_overflow();
    test_frame_flush();
    test_full_simul();
    test_same_cycle();
    test_merge();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
